axioma_timer_prescaler: RTL and testbench

//  Shared prescaler/clock-select controller for Timer0 and Timer1 (ATmega328P style).
//  - Runs one 10-bit free-running prescaler.
//  - Owns GTCCR (TSM, PSRSYNC) for synchronized timer start/halt.
//  - Turns each timer's CSn[2:0] selection into a one-cycle count-enable tick, including external T0/T1 pin clocks.
//  - Sits between the I/O bus and the timer cores; timers count only on their tick.

---
 rtl/axioma_timer_prescaler.sv | 132 +++++++++++++
 tb/tb_axioma_timer_prescaler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axioma_timer_prescaler.sv
// Shared Timer0/Timer1 prescaler and clock-select controller with GTCCR (TSM, PSRSYNC).
// One free-running 10-bit prescaler feeds a per-timer tap/external-pin tick lane.

module axioma_timer_prescaler_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] cs_i,
  input  logic [9:0] cnt_i,
  input  logic       pin_i,
  input  logic       hold_d_i,
  output logic       tick_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_q, tick_d;
  logic                   sel;
  logic                   rise, fall;

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & edge_q;

  always_comb begin
    sel = 1'b0;
    case (cs_i)
      3'b000:  sel = 1'b0;
      3'b001:  sel = 1'b1;
      3'b010:  sel = &cnt_i[2:0];
      3'b011:  sel = &cnt_i[5:0];
      3'b100:  sel = &cnt_i[7:0];
      3'b101:  sel = &cnt_i;
      3'b110:  sel = fall;
      default: sel = rise;
    endcase
    // mask with the upcoming hold so no tick is ever visible while psr_hold is high
    tick_d = sel & ~hold_d_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      edge_q <= sync_q[SYNC_STAGES-1];
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
endmodule

module axioma_timer_prescaler #(
  parameter logic [5:0] GTCCR_ADDR  = 6'h23,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] io_addr,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [2:0] cs0,
  input  logic [2:0] cs1,
  input  logic       t0_pin,
  input  logic       t1_pin,
  output logic       tick0,
  output logic       tick1,
  output logic       psr_hold,
  output logic [9:0] debug_prescaler
);
  localparam int NUM_LANES = 2;

  logic       tsm_q, tsm_d;
  logic       psr_q, psr_d;
  logic [9:0] cnt_q, cnt_d;
  logic       gtccr_wr, psr_set, hold_d;
  logic       unused_bits;

  logic [NUM_LANES-1:0][2:0] cs_v;
  logic [NUM_LANES-1:0]      pin_v;
  logic [NUM_LANES-1:0]      tick_v;

  assign gtccr_wr = io_write && (io_addr == GTCCR_ADDR);
  assign psr_set  = gtccr_wr & io_data_in[0];
  assign psr_hold = tsm_q & psr_q;

  always_comb begin
    tsm_d = gtccr_wr ? io_data_in[7] : tsm_q;
    // PSRSYNC only survives the edge when TSM is (still) set; otherwise it self-clears
    psr_d  = (psr_q | psr_set) & tsm_d;
    hold_d = tsm_d & psr_d;
    cnt_d  = (psr_hold | psr_set) ? 10'd0 : cnt_q + 10'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tsm_q <= 1'b0;
      psr_q <= 1'b0;
      cnt_q <= 10'd0;
    end else begin
      tsm_q <= tsm_d;
      psr_q <= psr_d;
      cnt_q <= cnt_d;
    end
  end

  assign io_data_out = (io_read && (io_addr == GTCCR_ADDR)) ? {tsm_q, 6'b0, psr_q} : 8'h00;
  assign debug_prescaler = cnt_q;
  assign unused_bits = ^io_data_in[6:1];

  assign cs_v  = {cs1, cs0};
  assign pin_v = {t1_pin, t0_pin};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axioma_timer_prescaler_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .cs_i     (cs_v[g]),
      .cnt_i    (cnt_q),
      .pin_i    (pin_v[g]),
      .hold_d_i (hold_d),
      .tick_o   (tick_v[g])
    );
  end

  assign tick0 = tick_v[0];
  assign tick1 = tick_v[1];
endmodule

// File: tb/tb_axioma_timer_prescaler.sv
// Bench for axioma_timer_prescaler: vector table, directed corner sequences, and a
// randomized run checked every cycle against a cycle-level behavioural model.

module tb_axioma_timer_prescaler;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] io_addr = 6'd0;
  logic [7:0] io_data_in = 8'd0;
  logic [7:0] io_data_out;
  logic       io_read = 1'b0, io_write = 1'b0;
  logic [2:0] cs0 = 3'd0, cs1 = 3'd0;
  logic       t0_pin = 1'b0, t1_pin = 1'b0;
  logic       tick0, tick1, psr_hold;
  logic [9:0] debug_prescaler;

  axioma_timer_prescaler dut (
    .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .io_data_in(io_data_in),
    .io_data_out(io_data_out), .io_read(io_read), .io_write(io_write),
    .cs0(cs0), .cs1(cs1), .t0_pin(t0_pin), .t1_pin(t1_pin),
    .tick0(tick0), .tick1(tick1), .psr_hold(psr_hold), .debug_prescaler(debug_prescaler)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: GTCCR bits, prescaler as an integer, pin sample histories.
  bit m_tsm, m_psr, m_t0, m_t1;
  int m_cnt;
  bit p0[$], p1[$];
  bit m_wr, m_hold_old, m_hold_new, r0, f0, r1, f1;

  function automatic bit want_tick(input logic [2:0] cs, input int c, input bit r, input bit f);
    case (cs)
      3'd0:    return 1'b0;
      3'd1:    return 1'b1;
      3'd2:    return (c % 8) == 7;
      3'd3:    return (c % 64) == 63;
      3'd4:    return (c % 256) == 255;
      3'd5:    return (c % 1024) == 1023;
      3'd6:    return f;
      default: return r;
    endcase
  endfunction

  task automatic model_reset();
    m_tsm = 0; m_psr = 0; m_t0 = 0; m_t1 = 0; m_cnt = 0;
    p0 = '{0, 0, 0, 0};
    p1 = '{0, 0, 0, 0};
  endtask

  task automatic model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_hold_old = m_tsm & m_psr;
    m_wr = io_write && (io_addr == 6'h23);
    // samples taken at this edge; a pin edge seen SYNC_STAGES samples ago ticks now
    p0.push_front(t0_pin); void'(p0.pop_back());
    p1.push_front(t1_pin); void'(p1.pop_back());
    r0 = p0[2] && !p0[3]; f0 = !p0[2] && p0[3];
    r1 = p1[2] && !p1[3]; f1 = !p1[2] && p1[3];
    if (m_wr) m_tsm = io_data_in[7];
    if (m_wr && io_data_in[0]) m_psr = 1;
    if (!m_tsm) m_psr = 0;
    m_hold_new = m_tsm & m_psr;
    m_t0 = !m_hold_new && want_tick(cs0, m_cnt, r0, f0);
    m_t1 = !m_hold_new && want_tick(cs1, m_cnt, r1, f1);
    m_cnt = (m_hold_old || (m_wr && io_data_in[0])) ? 0 : (m_cnt + 1) % 1024;
  endtask

  task automatic compare_all();
    chk("m_tick0", tick0, m_t0);
    chk("m_tick1", tick1, m_t1);
    chk("m_hold", psr_hold, m_tsm & m_psr);
    chk("m_count", debug_prescaler, m_cnt);
    chk("m_rdata", io_data_out,
        (io_read && io_addr == 6'h23) ? {24'd0, m_tsm, 6'b0, m_psr} : 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [7:0] d);
    io_write = 1'b1; io_addr = 6'h23; io_data_in = d;
    cyc();
    io_write = 1'b0;
  endtask

  typedef struct {
    logic [2:0] c0;
    logic [2:0] c1;
    int         n;
    int         e0;
    int         e1;
    bit         coinc;
  } vec_t;

  vec_t vt[6];
  int   n0, n1, hold0, hold1;

  initial begin
    vt[0] = '{3'd2, 3'd0, 64,   8,  0,  0};
    vt[1] = '{3'd3, 3'd4, 512,  8,  2,  0};
    vt[2] = '{3'd5, 3'd3, 2048, 2,  32, 1};
    vt[3] = '{3'd1, 3'd2, 40,   40, 5,  0};
    vt[4] = '{3'd6, 3'd7, 30,   0,  0,  0};
    vt[5] = '{3'd0, 3'd1, 25,   0,  25, 0};

    model_reset();
    cs0 = 3'd2;
    io_read = 1'b1; io_addr = 6'h23;
    repeat (2) cyc();
    chk("rst_tick0", tick0, 0);
    chk("rst_hold", psr_hold, 0);
    chk("rst_count", debug_prescaler, 0);
    chk("rst_gtccr", io_data_out, 0);
    io_read = 1'b0;

    // release: /8 tick first 8 edges later, then every 8
    reset_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      chk("rel_tick0", tick0, (i % 8) == 0);
      chk("rel_tick1", tick1, 0);
    end

    foreach (vt[k]) begin
      cs0 = vt[k].c0; cs1 = vt[k].c1;
      wr(8'h01);
      n0 = 0; n1 = 0;
      for (int j = 0; j < vt[k].n; j++) begin
        cyc();
        n0 += int'(tick0); n1 += int'(tick1);
        if (vt[k].coinc && tick0) chk("vec_coinc", tick1, 1);
      end
      chk($sformatf("vec%0d_n0", k), n0, vt[k].e0);
      chk($sformatf("vec%0d_n1", k), n1, vt[k].e1);
    end

    // synchronized halt
    cs0 = 3'd1; cs1 = 3'd0;
    wr(8'h81);
    io_read = 1'b1; io_addr = 6'h23;
    for (int i = 0; i < 500; i++) begin
      cyc();
      chk("halt_hold", psr_hold, 1);
      chk("halt_tick0", tick0, 0);
      chk("halt_count", debug_prescaler, 0);
      chk("halt_read", io_data_out, 8'h81);
    end
    cs0 = 3'd2;
    wr(8'h00);
    chk("unhalt_hold", psr_hold, 0);
    chk("unhalt_read", io_data_out, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("unhalt_tick0", tick0, j == 8);
    end
    io_read = 1'b0;

    // one-shot prescaler reset at count 5
    wr(8'h01);
    repeat (5) cyc();
    chk("psr5_count", debug_prescaler, 5);
    wr(8'h01);
    chk("psr5_zero", debug_prescaler, 0);
    io_read = 1'b1; io_addr = 6'h23;
    #1;
    chk("psr5_read", io_data_out, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("psr5_tick0", tick0, j == 8);
    end
    io_read = 1'b0;

    // external clock on T1: rising then falling edge select
    cs0 = 3'd0; cs1 = 3'd7; t1_pin = 1'b0;
    repeat (6) cyc();
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) t1_pin = ~t1_pin;
      cyc();
      chk("ext_rise", tick1, (i % 20) == 2);
    end
    cs1 = 3'd6;
    repeat (6) cyc();
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) t1_pin = ~t1_pin;
      cyc();
      chk("ext_fall", tick1, (i % 20) == 12);
    end

    // async reset mid-count
    cs0 = 3'd1; cs1 = 3'd0;
    wr(8'h80);
    repeat (20) cyc();
    chk("pre_rst_tick0", tick0, 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_tick0", tick0, 0);
    chk("arst_count", debug_prescaler, 0);
    chk("arst_hold", psr_hold, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    io_read = 1'b1; io_addr = 6'h23;
    #1;
    chk("arst_read", io_data_out, 8'h00);

    // randomized traffic against the model
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) cs0 = 3'($urandom_range(7));
      if ($urandom_range(49) == 0) cs1 = 3'($urandom_range(7));
      io_write = ($urandom_range(39) == 0);
      io_addr  = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'h23;
      case ($urandom_range(4))
        0: io_data_in = 8'h81;
        1: io_data_in = 8'h00;
        2: io_data_in = 8'h01;
        3: io_data_in = 8'h80;
        default: io_data_in = 8'($urandom_range(255));
      endcase
      io_read = 1'($urandom_range(1));
      hold0++; hold1++;
      if (hold0 >= 2 && $urandom_range(3) == 0) begin t0_pin = ~t0_pin; hold0 = 0; end
      if (hold1 >= 2 && $urandom_range(3) == 0) begin t1_pin = ~t1_pin; hold1 = 0; end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
